ff_frame_assembler: RTL
=======================

// Module: ff_frame_assembler
// PURPOSE
//  Parametrised ff_clk-domain frame assembler feeding the MII transmit path.
//  Collects PAYLOAD_BEATS beats of DATA_W-bit demodulator data behind a latched
//  HDR_W-bit frame id into a ring of NUM_BUF register buffers.
//  Hands completed frames to the phy_txclk-side sender via a toggle with release
//  flow control. Adds frame dropping on overrun, abort on start loss, and a nibble read port.
// PARAMETERS
//  DATA_W        1    bits per ff_en beat
//  HDR_W         24   frame id width, stored at frame bits [HDR_W-1:0]
//  PAYLOAD_BEATS 625  beats per frame; FRAME_BITS = HDR_W + PAYLOAD_BEATS*DATA_W (649)
//  PAD_BITS      656  padded frame length, multiple of RD_W, >= FRAME_BITS
//  NUM_BUF       2    ring depth, power of 2, >= 2
//  RD_W          4    read-port chunk width
// PORTS
//  ff_clk      in   1                 capture clock (about 207.8 kHz)
//  reset       in   1                 synchronous, active-high
//  ff_en       in   1                 beat strobe; ff_data valid when high
//  ff_data     in   DATA_W            payload beat, earliest beat at lowest payload position
//  start       in   1                 capture enable; low aborts any partial frame
//  frameid     in   HDR_W             sampled on the first beat of each frame
//  rel_toggle  in   1                 async release toggle from consumer; each edge frees oldest
//  rd_addr     in   $clog2(PAD_BITS/RD_W)  chunk index inside buffer rd_head
//  rd_data     out  RD_W              combinational bits [rd_addr*RD_W +: RD_W] of buffer rd_head
//  rd_head     out  $clog2(NUM_BUF)   index of oldest committed frame
//  frm_toggle  out  1                 flips once per committed frame
//  pending     out  $clog2(NUM_BUF)+1 committed, unreleased frames
//  busy        out  1                 frame fill in progress (FILL or DROP)
//  overflow    out  1                 sticky; set when a frame is dropped
//  drop_cnt    out  8                 dropped frames, saturates at 255
// BEHAVIOUR
//  Reset values:
//   - state=IDLE; wr_idx, rd_head, pending, frm_toggle, overflow, drop_cnt, beat_cnt = 0.
//   - Release synchroniser is preloaded with rel_toggle's sampled value; no spurious release.
//   - Buffer contents are not reset.
//  Pause: all states hold when ff_en=0.
//  IDLE, on ff_en & start:
//   - pending < NUM_BUF: write {frameid} to [HDR_W-1:0] of buf[wr_idx], write beat 0,
//     beat_cnt=1, go to FILL.
//   - pending == NUM_BUF: go to DROP, beat_cnt=1, set overflow, drop_cnt += 1 (saturating).
//  FILL, per ff_en & start:
//   - Write beat k to bits [HDR_W+k*DATA_W +: DATA_W]; beat_cnt += 1.
//   - On beat PAYLOAD_BEATS-1, commit in the same edge:
//     frm_toggle flips, pending += 1, wr_idx = (wr_idx+1) mod NUM_BUF, go to IDLE.
//  DROP: counts beats identically to FILL, writes nothing; on the last beat goes to IDLE, no commit.
//  start=0 in FILL or DROP: abort.
//   - Next edge: IDLE, beat_cnt=0, wr_idx unchanged, partial data discarded.
//   - No toggle; drop_cnt unchanged.
//  Bits [PAD_BITS-1:FRAME_BITS] of every buffer are zero, written on the first beat.
//  Release: rel_toggle passes through a 2-flop synchroniser, then edge detect.
//   - Each detected edge: rd_head = (rd_head+1) mod NUM_BUF, pending -= 1.
//   - Latency: 3 ff_clk edges after rel_toggle changes.
//   - Edge with pending=0: ignored, nothing underflows.
//  Commit and release on the same edge: pending unchanged, wr_idx and rd_head both advance.
//  A committed buffer is never written until released; rd_data stays stable while pending>0.
//  Consumer detects frm_toggle change (sync in its domain), reads rd_head, toggles rel_toggle.
//  reset mid-frame: immediate return to reset values; the partial frame is lost.
// TESTING
//  1. DATA_W=1, frameid=24'hABCDEF, 625 beats of alternating 1/0
//     -> frm_toggle=1, pending=1; chunk 0 = 4'hF, chunk 6 = 4'h5, chunk 163 = 4'h0.
//  2. Three frames without release, NUM_BUF=2
//     -> pending=2; third frame dropped; overflow=1, drop_cnt=1, frm_toggle flipped twice only.
//  3. start low after 100 beats, then a full frame
//     -> one commit; the buffer holds only the second frame; wr_idx advanced once.
//  4. Release toggle on the same edge as the 2nd commit, pending=1 before
//     -> pending stays 1; rd_head=1, wr_idx=0.
//  5. ff_en gaps of random length inside a frame -> payload identical to the gap-free run.
//  6. reset at beat 300, then a full frame -> frm_toggle=1, pending=1, overflow=0.

Source files
------------

// File: rtl/ff_frame_assembler.sv
// ff_frame_assembler
//   Collects PAYLOAD_BEATS beats of DATA_W-bit demodulator data into a ring of
//   NUM_BUF register buffers. Each buffer starts with a latched HDR_W-bit frame id.
//   Each completed frame is announced to the transmit-clock side by flipping
//   frm_toggle. The consumer frees the oldest buffer by flipping rel_toggle.
//   A frame that arrives while the ring is full is counted and dropped.
//   Deasserting start abandons a partial frame.
//
// Ports
//   ff_clk      capture clock
//   reset       synchronous, active-high
//   ff_en       beat strobe, ff_data valid when high
//   ff_data     payload beat, earliest beat at lowest payload position
//   start       capture enable, low aborts a partial frame
//   frameid     frame id, sampled on the first beat of a frame
//   rel_toggle  asynchronous release toggle, each edge frees the oldest frame
//   rd_addr     RD_W-bit chunk index into buffer rd_head
//   rd_data     combinational chunk rd_addr of buffer rd_head
//   rd_head     index of the oldest committed frame
//   frm_toggle  flips once per committed frame
//   pending     committed, unreleased frames
//   busy        frame fill in progress (filling or dropping)
//   overflow    sticky, set when a frame is dropped
//   drop_cnt    dropped frames, saturates at 255
module ff_frame_assembler #(
    parameter int unsigned DATA_W        = 1,
    parameter int unsigned HDR_W         = 24,
    parameter int unsigned PAYLOAD_BEATS = 625,
    parameter int unsigned PAD_BITS      = 656,
    parameter int unsigned NUM_BUF       = 2,
    parameter int unsigned RD_W          = 4
) (
    input  logic                                ff_clk,
    input  logic                                reset,
    input  logic                                ff_en,
    input  logic [DATA_W-1:0]                   ff_data,
    input  logic                                start,
    input  logic [HDR_W-1:0]                    frameid,
    input  logic                                rel_toggle,
    input  logic [$clog2(PAD_BITS/RD_W)-1:0]    rd_addr,
    output logic [RD_W-1:0]                     rd_data,
    output logic [$clog2(NUM_BUF)-1:0]          rd_head,
    output logic                                frm_toggle,
    output logic [$clog2(NUM_BUF):0]            pending,
    output logic                                busy,
    output logic                                overflow,
    output logic [7:0]                          drop_cnt
);

    localparam int unsigned IDX_W  = $clog2(NUM_BUF);
    localparam int unsigned PEND_W = IDX_W + 1;
    localparam int unsigned CHUNKS = PAD_BITS / RD_W;
    localparam int unsigned RA_W   = $clog2(CHUNKS);
    localparam int unsigned BEAT_W = $clog2(PAYLOAD_BEATS);
    localparam int unsigned POS_W  = $clog2(PAD_BITS);

    localparam logic [PEND_W-1:0] RING_FULL = PEND_W'(NUM_BUF);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PAYLOAD_BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DROP
    } state_t;

    state_t              state_q,      state_d;
    logic [BEAT_W-1:0]   beat_cnt_q,   beat_cnt_d;
    logic [IDX_W-1:0]    wr_idx_q,     wr_idx_d;
    logic [IDX_W-1:0]    rd_head_q,    rd_head_d;
    logic [PEND_W-1:0]   pending_q,    pending_d;
    logic                frm_toggle_q, frm_toggle_d;
    logic                overflow_q,   overflow_d;
    logic [7:0]          drop_cnt_q,   drop_cnt_d;
    logic                rel_s1_q, rel_s2_q, rel_s3_q;

    logic [PAD_BITS-1:0] buf_q [NUM_BUF];

    logic                commit;
    logic                rel_ok;
    logic                wr_first;
    logic                wr_beat;
    logic [POS_W-1:0]    wr_pos;
    logic [PAD_BITS-1:0] first_word;
    logic [PAD_BITS-1:0] head_word;

    // State register
    always_ff @(posedge ff_clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            beat_cnt_q   <= '0;
            wr_idx_q     <= '0;
            rd_head_q    <= '0;
            pending_q    <= '0;
            frm_toggle_q <= 1'b0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= '0;
            // Preloading the whole chain makes a toggle level held through reset look like "no edge".
            rel_s1_q     <= rel_toggle;
            rel_s2_q     <= rel_toggle;
            rel_s3_q     <= rel_toggle;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            wr_idx_q     <= wr_idx_d;
            rd_head_q    <= rd_head_d;
            pending_q    <= pending_d;
            frm_toggle_q <= frm_toggle_d;
            overflow_q   <= overflow_d;
            drop_cnt_q   <= drop_cnt_d;
            rel_s1_q     <= rel_toggle;
            rel_s2_q     <= rel_s1_q;
            rel_s3_q     <= rel_s2_q;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        wr_idx_d     = wr_idx_q;
        rd_head_d    = rd_head_q;
        frm_toggle_d = frm_toggle_q;
        overflow_d   = overflow_q;
        drop_cnt_d   = drop_cnt_q;
        commit       = 1'b0;

        // A release edge with nothing pending is discarded.
        rel_ok = (rel_s2_q ^ rel_s3_q) && (pending_q != '0);

        unique case (state_q)
            S_IDLE: begin
                if (ff_en && start) begin
                    beat_cnt_d = BEAT_W'(1);
                    if (pending_q < RING_FULL) begin
                        state_d = S_FILL;
                    end else begin
                        state_d    = S_DROP;
                        overflow_d = 1'b1;
                        if (drop_cnt_q != 8'hFF) begin
                            drop_cnt_d = drop_cnt_q + 8'd1;
                        end
                    end
                end
            end
            S_FILL, S_DROP: begin
                // Abort does not wait for a beat strobe.
                if (!start) begin
                    state_d    = S_IDLE;
                    beat_cnt_d = '0;
                end else if (ff_en) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d    = S_IDLE;
                        beat_cnt_d = '0;
                        commit     = (state_q == S_FILL);
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    end
                end
            end
            default: begin
                state_d    = S_IDLE;
                beat_cnt_d = '0;
            end
        endcase

        if (commit) begin
            frm_toggle_d = ~frm_toggle_q;
            wr_idx_d     = wr_idx_q + IDX_W'(1);
        end
        if (rel_ok) begin
            rd_head_d = rd_head_q + IDX_W'(1);
        end
        pending_d = pending_q + PEND_W'(commit) - PEND_W'(rel_ok);
    end

    // Output logic
    always_comb begin
        busy     = (state_q != S_IDLE);
        wr_first = (state_q == S_IDLE) && ff_en && start && (pending_q < RING_FULL);
        wr_beat  = (state_q == S_FILL) && ff_en && start;
        wr_pos   = POS_W'(HDR_W) + POS_W'(beat_cnt_q) * POS_W'(DATA_W);

        // The first beat writes the whole buffer, which clears the padding bits.
        first_word                    = '0;
        first_word[HDR_W-1:0]         = frameid;
        first_word[HDR_W +: DATA_W]   = ff_data;

        head_word = buf_q[rd_head_q];
        rd_data   = '0;
        for (int unsigned c = 0; c < CHUNKS; c++) begin
            if (rd_addr == RA_W'(c)) begin
                rd_data = head_word[c*RD_W +: RD_W];
            end
        end

        rd_head    = rd_head_q;
        frm_toggle = frm_toggle_q;
        pending    = pending_q;
        overflow   = overflow_q;
        drop_cnt   = drop_cnt_q;
    end

    // Frame storage, deliberately not reset
    always_ff @(posedge ff_clk) begin
        if (!reset) begin
            if (wr_first) begin
                buf_q[wr_idx_q] <= first_word;
            end else if (wr_beat) begin
                buf_q[wr_idx_q][wr_pos +: DATA_W] <= ff_data;
            end
        end
    end

endmodule
